seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Parametrised time-multiplexed display scanner for common-anode/cathode 7-seg banks.
//  Generates its own digit-select rotation from a clock prescaler and inserts an all-off
//  blanking interval at each digit change to suppress ghosting.
//  Snapshots all digit patterns at frame start so a frame never shows mixed old/new data.
//  Sits between the digit decoders and the board's segment/anode pins.
// PARAMETERS
//  NUM_DIGITS      4     digits scanned; >=2
//  SEG_W           8     segment bits per digit (7 seg + dp)
//  DIV             1000  clk cycles per digit slot, blanking included; >=2
//  BLANK           50    blanking cycles at start of each slot; 0 <= BLANK < DIV
//  SEL_ACTIVE_LOW  1     1: sel_out asserted low; 0: asserted high
//  SEG_ACTIVE_LOW  1     1: seg_out lit = 0; 0: lit = 1
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  asynchronous reset, active low
//  enable       in   1                  1 = scan; 0 = display dark
//  digits_in    in   NUM_DIGITS*SEG_W   digit i at [i*SEG_W +: SEG_W]; bit=1 means lit
//  seg_out      out  SEG_W              segment drive, polarity per SEG_ACTIVE_LOW
//  sel_out      out  NUM_DIGITS         one-hot digit select, polarity per SEL_ACTIVE_LOW
//  digit_idx    out  clog2(NUM_DIGITS)  index of digit in current slot
//  frame_start  out  1                  1-cycle pulse on first cycle of digit 0 slot
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, counters 0, snapshot 0, digit_idx 0,
//    frame_start 0, seg_out and sel_out all inactive (unlit / deselected).
//  - All outputs registered; they change on the same edge as the state register.
//  - States: IDLE, BLANK, DRIVE. Slot counter cnt 0..DIV-1, digit index idx.
//  - IDLE: outputs inactive. enable=1 sampled -> next edge: BLANK (DRIVE if BLANK=0),
//    idx=0, cnt=0, snapshot<=digits_in, frame_start=1 for that cycle.
//  - BLANK: seg/sel inactive; cnt++; at cnt==BLANK-1 -> DRIVE.
//  - DRIVE: sel_out[idx] asserted only; seg_out = snapshot digit idx; cnt++.
//  - At cnt==DIV-1: cnt<=0, idx<=idx+1; wrap NUM_DIGITS-1 -> 0 with
//    snapshot<=digits_in and frame_start=1; next state BLANK (DRIVE if BLANK=0).
//  - Slot length exactly DIV cycles; frame period exactly NUM_DIGITS*DIV cycles.
//  - digits_in changes mid-frame have no effect until next frame boundary.
//  - enable=0 in any non-IDLE state: next edge -> IDLE, outputs inactive, cnt/idx cleared;
//    re-enable restarts at digit 0 with fresh snapshot and frame_start.
//  - Reset mid-operation: immediate inactive outputs regardless of clk.
//  - Never two sel bits asserted; sel never asserted during BLANK or IDLE.
//  - Non-power-of-2 NUM_DIGITS: idx wraps at NUM_DIGITS-1, never reaches unused codes.
// TESTING (NUM_DIGITS=4, SEG_W=8, DIV=8, BLANK=2, both ACTIVE_LOW=1 unless noted)
//  - Reset: rst_n=0 asynchronously mid-DRIVE -> seg_out=8'hFF, sel_out=4'hF at once.
//  - Scan: digits_in={8'h44,8'h33,8'h22,8'h11}, enable=1 -> per slot 2 cycles
//    sel=F/seg=FF then 6 cycles sel=E,D,B,7 with seg=EE,DD,CC,BB; frame_start every 32.
//  - Tearing: change digits_in to all 8'h0F during digit 2 slot -> digits 2,3 still old;
//    next frame all show seg=F0.
//  - Enable drop: enable=0 in cycle 4 of digit 1 -> next edge IDLE, dark; enable=1 ->
//    frame_start, digit 0 slot begins with blanking.
//  - BLANK=0, DIV=2: no blank cycles, sel rotates E,D,B,7 every 2 cycles.
//  - NUM_DIGITS=3, SEL_ACTIVE_LOW=0: sel_out 001,010,100,001...; never 000 outside blank.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//   Time-multiplexed scanner for a bank of 7-segment digits. A prescaler
//   divides each digit slot into DIV clocks. The first BLANK clocks of every
//   slot drive nothing, which suppresses ghosting. All digit patterns are
//   captured at the start of each frame, so one frame never mixes old and new
//   data. Every output comes from a register and is updated on the same edge
//   as the state register.
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   enable       1 = scan, 0 = display dark (the scanner returns to idle)
//   digits_in    digit i at [i*SEG_W +: SEG_W]; a 1 bit means lit
//   seg_out      segment drive; polarity set by SEG_ACTIVE_LOW
//   sel_out      one-hot digit select; polarity set by SEL_ACTIVE_LOW
//   digit_idx    index of the digit that owns the current slot
//   frame_start  1-cycle pulse on the first cycle of the digit 0 slot
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_W          = 8,
    parameter int DIV            = 1000,
    parameter int BLANK          = 50,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       sel_out,
    output logic [IDX_W-1:0]            digit_idx,
    output logic                        frame_start
);

    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DIV - 1);
    // Only compared while in the blanking state, which does not exist when BLANK == 0.
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK == 0) ? 0 : BLANK - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    // Every slot opens in blanking unless blanking is disabled.
    localparam state_t SLOT_FIRST = (BLANK == 0) ? S_DRIVE : S_BLANK;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS*SEG_W-1:0] snap_q, snap_d;
    logic [SEG_W-1:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       sel_q, sel_d;
    logic                        fs_q, fs_d;

    logic [NUM_DIGITS-1:0]       sel_act;
    logic [SEG_W-1:0]            seg_lit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = SLOT_FIRST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    snap_d  = digits_in;
                    fs_d    = 1'b1;
                end
            end
            default: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SLOT_FIRST;
                    if (idx_q == IDX_LAST) begin
                        // A frame boundary is the only point where new data is accepted.
                        idx_d  = '0;
                        snap_d = digits_in;
                        fs_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == S_BLANK && cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                    end
                end
            end
        endcase
    end

    // The output registers are computed from the next state, so they move
    // together with the state register instead of one cycle behind it.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign sel_act[gi] = (state_d == S_DRIVE) && (idx_d == IDX_W'(gi));
    end

    always_comb begin
        seg_lit = '0;
        if (state_d == S_DRIVE) begin
            seg_lit = snap_d[idx_d*SEG_W +: SEG_W];
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
        sel_d = (SEL_ACTIVE_LOW != 0) ? ~sel_act : sel_act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            seg_q   <= SEG_OFF;
            sel_q   <= SEL_OFF;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign sel_out     = sel_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
//   Drives two scanner configurations from one shared stimulus:
//     A: 4 digits, DIV=8, BLANK=2, both outputs active low
//     B: 3 digits, DIV=2, BLANK=0, active-high select, active-low segments
//   A reference model runs on each clock edge. It knows only the number of
//   cycles since the scan started and the pattern captured at the frame
//   boundary. It pushes the expected outputs into one queue per instance, and
//   a monitor on the falling edge pops each entry and compares it.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] digits = '0;

    logic [7:0]  seg_a;
    logic [3:0]  sel_a;
    logic [1:0]  idx_a;
    logic        fs_a;
    logic [7:0]  seg_b;
    logic [2:0]  sel_b;
    logic [1:0]  idx_b;
    logic        fs_b;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS(4), .SEG_W(8), .DIV(8), .BLANK(2),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits),
        .seg_out(seg_a), .sel_out(sel_a), .digit_idx(idx_a), .frame_start(fs_a)
    );

    seg_scan_mux #(
        .NUM_DIGITS(3), .SEG_W(8), .DIV(2), .BLANK(0),
        .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits[23:0]),
        .seg_out(seg_b), .sel_out(sel_b), .digit_idx(idx_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Model state per instance: whether the scan is running, the number of
    // cycles since it started, and the patterns captured for the current frame.
    bit          run_m[2];
    int          k_m[2];
    logic [31:0] snap_m[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Expected outputs for scan cycle k, derived from the slot and frame arithmetic.
    function automatic exp_t model_out(bit run, int k, logic [31:0] snap, int n, int dv,
                                       int bl, bit sel_low, bit seg_low);
        exp_t       e;
        logic [7:0] lit;
        logic [3:0] act;
        int         slot;
        int         pos;
        lit   = '0;
        act   = '0;
        e.idx = '0;
        e.fs  = 1'b0;
        if (run) begin
            slot  = (k / dv) % n;
            pos   = k % dv;
            e.idx = slot[1:0];
            e.fs  = ((k % (n * dv)) == 0);
            if (pos >= bl) begin
                act[slot] = 1'b1;
                lit       = snap[slot*8 +: 8];
            end
        end
        e.sel = sel_low ? ~act : act;
        e.seg = seg_low ? ~lit : lit;
        return e;
    endfunction

    task automatic model_step(input int inst, input int n, input int dv, input int bl,
                              input bit sel_low, input bit seg_low, input logic [31:0] digs);
        exp_t e;
        if (!rst_n) begin
            run_m[inst] = 1'b0;
        end else if (!run_m[inst]) begin
            if (enable) begin
                run_m[inst]  = 1'b1;
                k_m[inst]    = 0;
                snap_m[inst] = digs;
            end
        end else if (!enable) begin
            run_m[inst] = 1'b0;
        end else begin
            k_m[inst]++;
            if ((k_m[inst] % (n * dv)) == 0) snap_m[inst] = digs;
        end
        e = model_out(run_m[inst], k_m[inst], snap_m[inst], n, dv, bl, sel_low, seg_low);
        if (inst == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    always @(posedge clk) begin
        cycle++;
        model_step(0, 4, 8, 2, 1'b1, 1'b1, digits);
        model_step(1, 3, 2, 0, 1'b0, 1'b1, {8'h00, digits[23:0]});
    end

    // Monitor: while reset is asserted the pending expectations are dropped,
    // because the reset path is checked directly by the stimulus.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            if (rst_n) begin
                check("A.seg", 32'(seg_a), 32'(e.seg));
                check("A.sel", 32'(sel_a), 32'(e.sel));
                check("A.idx", 32'(idx_a), 32'(e.idx));
                check("A.frame_start", 32'(fs_a), 32'(e.fs));
                if (e.fs)
                    $display("[TB] cycle %0d: A frame start, sel=%h seg=%h", cycle, sel_a, seg_a);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            if (rst_n) begin
                check("B.seg", 32'(seg_b), 32'(e.seg));
                check("B.sel", 32'(sel_b), 32'(e.sel[2:0]));
                check("B.idx", 32'(idx_b), 32'(e.idx));
                check("B.frame_start", 32'(fs_b), 32'(e.fs));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rst.segA"}, 32'(seg_a), 32'h0000_00FF);
        check({tag, ".rst.selA"}, 32'(sel_a), 32'h0000_000F);
        check({tag, ".rst.idxA"}, 32'(idx_a), 32'h0);
        check({tag, ".rst.fsA"},  32'(fs_a),  32'h0);
        check({tag, ".rst.segB"}, 32'(seg_b), 32'h0000_00FF);
        check({tag, ".rst.selB"}, 32'(sel_b), 32'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("init");
        tick(3);
        rst_n = 1'b1;

        // Directed scan pattern.
        tick(1);
        digits = 32'h4433_2211;
        enable = 1'b1;
        // Change the data part-way through the digit 2 slot of frame 1.
        tick(19);
        digits = 32'h0F0F_0F0F;
        tick(50);

        // Drop enable in the middle of a slot, then restart the scan.
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(12);
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(40);

        // Randomised run.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 4) == 0) digits = $urandom;
            tick(1);
        end

        // Asynchronous reset while A is in its drive phase.
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        tick(2);
        rst_n = 1'b1;
        tick(40);

        enable = 1'b0;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
